mux2_arbiter: RTL and testbench
===============================

Name: mux2_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 2:1 mux datapath.
- Accepts requests from two sources and grants ownership to at most one of them at a time.
- Drives the mux select line. Inserts configurable dead cycles between owners so the mux output never glitches between two granted sources.
- Sits directly in front of the mux instance; its `sel` output connects to the mux select pin.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one owner while the other source is waiting. Legal range 2..255. Used only with HOLD_LIMIT_EN.
- DEAD_CYCLES, 1: cycles with no grant between a release and the next owner's grant. Legal range 0..3.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req  input  2  request; `req[n]` high = source n wants the mux (level, held while using)
- gnt  output 2  one-hot-or-zero grant; `gnt[n]` = source n owns the mux
- sel  output 1  mux select; 0 = source 0, 1 = source 1
- busy output 1  high whenever in GRANT0, GRANT1 or DEAD
- last output 1  index of the most recently granted source (round-robin pointer)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: gnt=00, sel=0, busy=0, last=1 (so source 0 wins the first tie), state=IDLE, hold counter=0, dead counter=0.
- Reset mid-operation: on the next edge with rst=1, all outputs return to reset values, regardless of state or pending requests.
- States: IDLE, GRANT0, GRANT1, DEAD.
- Latency: request seen in IDLE at edge k -> gnt and sel valid after edge k+1.
- IDLE:
  - req=00: stay; sel holds its previous value.
  - Exactly one bit set: go to GRANTn.
  - req=11: grant index `!last`.
  - Entering GRANTn sets sel=n and last=n in the same cycle gnt[n] rises.
- GRANTn:
  - Stay while req[n]=1 and no forced release.
  - Hold counter increments each grant cycle and saturates at MAX_HOLD.
  - On exit (req[n]=0, or forced release), the hold counter clears.
  - On exit with the other source requesting:
    - DEAD_CYCLES=0: go straight to GRANT(!n), swapping gnt and sel on the same edge.
    - DEAD_CYCLES>0: go to DEAD with target=!n.
  - On exit with the other source idle: go to IDLE with gnt=00.
  - Simultaneous req[n] fall and req[!n] rise: treated as a switch (other source requesting).
- DEAD:
  - gnt=00; sel keeps the old owner's value; busy=1.
  - Stays for exactly DEAD_CYCLES cycles.
  - Then grants the target: sel flips on the same edge gnt[target] rises.
  - If req[target] has dropped by the end of DEAD: grant the previous owner if it is requesting, else go to IDLE.
- The grant never changes while the owner holds req, except through a forced release (HOLD_LIMIT_EN).
- gnt is never 11 in any cycle.

Optional Feature:
- Macro: MUX2_ARB_HOLD_LIMIT_EN.
- Defined: when the hold counter reaches MAX_HOLD and req[!n]=1, the owner is forcibly released (treated as a release with the other source requesting). If the other source is idle, the owner keeps the grant and the counter stays saturated.
- Undefined: no forced release; the owner keeps the grant until it drops req. The hold counter logic is compiled out.

Decomposition:
- Package `mux2_arb_pkg`:
  - state enum type (IDLE, GRANT0, GRANT1, DEAD)
  - `HOLD_W` = $clog2(MAX_HOLD+1)
  - `DEAD_W` = 2
  - reset constants for gnt, sel and last
- Sub-module `mux2_arb_hold_cnt`: saturating counter with clear, increment and at-limit flag. Instantiated only under MUX2_ARB_HOLD_LIMIT_EN.

Test Plan:
- Reset, then req=11 at cycle 2 -> gnt=01, sel=0, last=0 after the next edge. Assert rst while granted -> gnt=00, sel=0, last=1, busy=0 one edge later.
- DEAD_CYCLES=1: owner 0 granted, req=10 (req[0] falls, req[1] held) -> one cycle gnt=00 with sel=0, then gnt=10, sel=1.
- Round-robin: alternate req=11 with req[owner] dropping after 3 cycles, for 6 handovers -> grants alternate 0,1,0,1,0,1; gnt never 11.
- With MUX2_ARB_HOLD_LIMIT_EN, MAX_HOLD=4: both req held high -> each owner granted exactly 4 cycles, separated by the dead gap. With only req[0] high -> gnt=01 held for 20 or more cycles.
- Target abandons during DEAD (DEAD_CYCLES=2): req[1] drops in DEAD cycle 1 and req[0] is high -> gnt=01 and sel stays 0. If both are low instead -> IDLE with gnt=00.
- DEAD_CYCLES=0: req[0] falls and req[1] rises on the same edge -> the next cycle shows gnt=10, sel=1, with no zero-grant cycle.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared types and constants for the 2:1 mux arbiter
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_DEAD   = 2'd3
    } arb_state_e;

    // Hold counter is sized for the largest legal MAX_HOLD so every build shares one width.
    localparam int MAX_HOLD_LIMIT = 255;
    localparam int HOLD_W         = $clog2(MAX_HOLD_LIMIT + 1);
    localparam int DEAD_W         = 2;

    localparam logic [1:0] GNT_RST  = 2'b00;
    localparam logic       SEL_RST  = 1'b0;
    localparam logic       LAST_RST = 1'b1;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mux2_arb_hold_cnt.sv
// rtl/mux2_arb_hold_cnt.sv - saturating grant-length counter with clear and at-limit flag
module mux2_arb_hold_cnt
    import mux2_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [HOLD_W-1:0] cnt_o,
    output logic              at_limit_o
);

    localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] ONE   = HOLD_W'(1);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // clr together with inc restarts the count at one: a new owner's first cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? ONE : '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - round-robin owner sequencer with dead gap for a 2:1 mux
// Optional forced release after MAX_HOLD cycles: define MUX2_ARB_HOLD_LIMIT_EN.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int MAX_HOLD    = 8,
    parameter int DEAD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       busy,
    output logic       last
);

    if ((MAX_HOLD < 2) || (MAX_HOLD > MAX_HOLD_LIMIT)) begin : g_bad_max_hold
        $error("mux2_arbiter: MAX_HOLD out of range 2..255");
    end
    if ((DEAD_CYCLES < 0) || (DEAD_CYCLES > 3)) begin : g_bad_dead_cycles
        $error("mux2_arbiter: DEAD_CYCLES out of range 0..3");
    end

    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_CYCLES > 0) ? (DEAD_CYCLES - 1) : 0);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              last_q, last_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              target_q, target_d;

    logic              cur_owner;
    logic              force_rel;
    logic              grant_en;
    logic              grant_idx;

    assign cur_owner = (state_q == ST_GRANT1);

`ifdef MUX2_ARB_HOLD_LIMIT_EN
    logic              hold_clr;
    logic              hold_inc;
    logic              hold_at_limit;
    logic [HOLD_W-1:0] hold_cnt;

    assign hold_inc = (state_d == ST_GRANT0) || (state_d == ST_GRANT1);
    assign hold_clr = ((state_q == ST_GRANT0) || (state_q == ST_GRANT1)) && (state_d != state_q);

    mux2_arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (hold_clr),
        .inc_i      (hold_inc),
        .cnt_o      (hold_cnt),
        .at_limit_o (hold_at_limit)
    );

    // A saturated owner only yields when the other side is actually waiting.
    assign force_rel = hold_at_limit && req[~cur_owner] &&
                       ((state_q == ST_GRANT0) || (state_q == ST_GRANT1));
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        target_d   = target_q;
        grant_en   = 1'b0;
        grant_idx  = sel_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req == 2'b11) begin
                    grant_en  = 1'b1;
                    grant_idx = ~last_q;
                end else if (req != 2'b00) begin
                    grant_en  = 1'b1;
                    grant_idx = req[1];
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!req[cur_owner] || force_rel) begin
                    if (req[~cur_owner]) begin
                        if (DEAD_CYCLES == 0) begin
                            grant_en  = 1'b1;
                            grant_idx = ~cur_owner;
                        end else begin
                            state_d    = ST_DEAD;
                            target_d   = ~cur_owner;
                            dead_cnt_d = '0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    // Target gave up during the gap: fall back to the previous owner if still asking.
                    if (req[target_q]) begin
                        grant_en  = 1'b1;
                        grant_idx = target_q;
                    end else if (req[~target_q]) begin
                        grant_en  = 1'b1;
                        grant_idx = ~target_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q + DEAD_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_en) begin
            state_d = grant_idx ? ST_GRANT1 : ST_GRANT0;
        end

        gnt_d  = 2'b00;
        if ((state_d == ST_GRANT0) || (state_d == ST_GRANT1)) begin
            gnt_d = onehot2(state_d == ST_GRANT1);
        end
        sel_d  = grant_en ? grant_idx : sel_q;
        last_d = grant_en ? grant_idx : last_q;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_RST;
            sel_q      <= SEL_RST;
            busy_q     <= 1'b0;
            last_q     <= LAST_RST;
            dead_cnt_q <= '0;
            target_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            dead_cnt_q <= dead_cnt_d;
            target_q   <= target_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;
    assign last = last_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - directed bench for mux2_arbiter at DEAD_CYCLES 1, 2 and 0
module tb_mux2_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_a, req_b, req_c;
    logic [1:0] gnt_a, gnt_b, gnt_c;
    logic       sel_a, sel_b, sel_c;
    logic       busy_a, busy_b, busy_c;
    logic       last_a, last_b, last_c;

    int total;
    int bad;
    bit done;

    mux2_arbiter #(.MAX_HOLD(4), .DEAD_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .last(last_a)
    );
    mux2_arbiter #(.MAX_HOLD(4), .DEAD_CYCLES(2)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .last(last_b)
    );
    mux2_arbiter #(.MAX_HOLD(4), .DEAD_CYCLES(0)) u_dut_c (
        .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .sel(sel_c), .busy(busy_c), .last(last_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!done) begin
            check("gnt_exclusive", 8'((gnt_a == 2'b11) || (gnt_b == 2'b11) || (gnt_c == 2'b11)), 8'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic e;
        total = 0;
        bad   = 0;
        done  = 1'b0;
        rst   = 1'b1;
        req_a = 2'b00;
        req_b = 2'b00;
        req_c = 2'b00;

        step();
        step();
        check("rst_gnt",  gnt_a,  2'b00);
        check("rst_sel",  sel_a,  1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_last", last_a, 1'b1);

        // Tie after reset goes to source 0, then a mid-grant reset clears everything.
        rst = 1'b0;
        step();
        step();
        req_a = 2'b11;
        step();
        check("tie_gnt",  gnt_a,  2'b01);
        check("tie_sel",  sel_a,  1'b0);
        check("tie_last", last_a, 1'b0);
        check("tie_busy", busy_a, 1'b1);
        rst = 1'b1;
        step();
        check("midrst_gnt",  gnt_a,  2'b00);
        check("midrst_sel",  sel_a,  1'b0);
        check("midrst_last", last_a, 1'b1);
        check("midrst_busy", busy_a, 1'b0);
        rst   = 1'b0;
        req_a = 2'b00;

        // Single dead cycle handover 0 -> 1.
        req_a = 2'b01;
        step();
        check("d1_own0", gnt_a, 2'b01);
        req_a = 2'b10;
        step();
        check("d1_gap_gnt",  gnt_a,  2'b00);
        check("d1_gap_sel",  sel_a,  1'b0);
        check("d1_gap_busy", busy_a, 1'b1);
        step();
        check("d1_own1_gnt",  gnt_a,  2'b10);
        check("d1_own1_sel",  sel_a,  1'b1);
        check("d1_own1_last", last_a, 1'b1);
        req_a = 2'b00;
        step();
        check("d1_idle_gnt",  gnt_a,  2'b00);
        check("d1_idle_busy", busy_a, 1'b0);
        check("d1_idle_sel",  sel_a,  1'b1);

        // Round robin over six handovers.
        pulse_reset();
        req_a = 2'b11;
        for (int i = 0; i < 6; i++) begin
            e = i[0];
            n = 0;
            while ((gnt_a == 2'b00) && (n < 8)) begin
                step();
                n++;
            end
            check("rr_owner", gnt_a, e ? 2'b10 : 2'b01);
            check("rr_sel",   sel_a, e);
            step();
            step();
            check("rr_held", gnt_a, e ? 2'b10 : 2'b01);
            req_a = e ? 2'b01 : 2'b10;
            step();
            check("rr_gap", gnt_a, 2'b00);
            req_a = 2'b11;
        end
        req_a = 2'b00;
        step();
        step();

`ifdef MUX2_ARB_HOLD_LIMIT_EN
        pulse_reset();
        req_a = 2'b11;
        step();
        check("hl_own0_c1", gnt_a, 2'b01);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hl_own0", gnt_a, 2'b01);
        end
        step();
        check("hl_gap0", gnt_a, 2'b00);
        step();
        check("hl_own1_c1", gnt_a, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hl_own1", gnt_a, 2'b10);
        end
        step();
        check("hl_gap1", gnt_a, 2'b00);
        step();
        check("hl_back0", gnt_a, 2'b01);
        pulse_reset();
        req_a = 2'b01;
        step();
        for (int i = 0; i < 20; i++) begin
            check("hl_alone", gnt_a, 2'b01);
            step();
        end
`else
        pulse_reset();
        req_a = 2'b11;
        step();
        for (int i = 0; i < 20; i++) begin
            check("nolimit_hold", gnt_a, 2'b01);
            step();
        end
`endif
        req_a = 2'b00;

        // Two dead cycles: target abandons, previous owner reclaims; then both abandon.
        pulse_reset();
        req_b = 2'b01;
        step();
        check("d2_own0", gnt_b, 2'b01);
        req_b = 2'b10;
        step();
        check("d2_dead1_gnt",  gnt_b,  2'b00);
        check("d2_dead1_busy", busy_b, 1'b1);
        req_b = 2'b01;
        step();
        check("d2_dead2_gnt", gnt_b, 2'b00);
        check("d2_dead2_sel", sel_b, 1'b0);
        step();
        check("d2_reclaim_gnt", gnt_b, 2'b01);
        check("d2_reclaim_sel", sel_b, 1'b0);
        req_b = 2'b10;
        step();
        req_b = 2'b00;
        step();
        check("d2_abandon_dead", gnt_b, 2'b00);
        check("d2_abandon_busy", busy_b, 1'b1);
        step();
        check("d2_idle_gnt",  gnt_b,  2'b00);
        check("d2_idle_busy", busy_b, 1'b0);
        check("d2_idle_sel",  sel_b,  1'b0);

        // No dead cycles: simultaneous fall/rise swaps in one edge.
        pulse_reset();
        req_c = 2'b01;
        step();
        check("d0_own0", gnt_c, 2'b01);
        req_c = 2'b10;
        step();
        check("d0_swap_gnt",  gnt_c,  2'b10);
        check("d0_swap_sel",  sel_c,  1'b1);
        check("d0_swap_busy", busy_c, 1'b1);
        check("d0_swap_last", last_c, 1'b1);
        req_c = 2'b00;
        step();

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
